// File: rtl/game_stage_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : game_stage_controller                                          |
// | Purpose  : Billiard game supervisor. Tracks coloured balls in play,       |
// |            awards BCD score per pocketed ball (double on the target      |
// |            hole), runs a per-stage countdown and a lives budget, and     |
// |            sequences stages 1..NUM_STAGES.                                |
// | Ports    : clk, reset        - clock, synchronous active-high reset      |
// |            startOfFrame      - frame strobe qualifying ball/hole inputs   |
// |            start_game        - leave IDLE / GAME_OVER / GAME_WON          |
// |            turbo             - one second = CLK_HZ/16 cycles              |
// |            balls_in_game     - per-ball on-table flags (bit 0 = white)    |
// |            ballhole_collide  - per-ball pocketed-this-frame flags         |
// |            curr_Hole_id      - hole of this frame's collision             |
// |            request_hole      - current target hole                        |
// |            stage_load        - one-cycle re-rack command                  |
// |            stage_num         - current stage                              |
// |            scoreL/scoreH     - BCD score digits                           |
// |            lives_left        - remaining lives                            |
// |            time_left         - remaining stage seconds                    |
// |            winPulse/losePulse- held high through the win / lose hold      |
// |            game_over/game_won- terminal state flags                       |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module game_stage_controller #(
    parameter int NUM_BALLS     = 2,
    parameter int NUM_STAGES    = 4,
    parameter int NUM_HOLES     = 6,
    parameter int LIVES         = 3,
    parameter int CLK_HZ        = 31_500_000,
    parameter int STAGE_SEC     = 60,
    parameter int WIN_HOLD_SEC  = 2,
    parameter int LOSE_HOLD_SEC = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 startOfFrame,
    input  logic                 start_game,
    input  logic                 turbo,
    input  logic [NUM_BALLS:0]   balls_in_game,
    input  logic [NUM_BALLS:0]   ballhole_collide,
    input  logic [2:0]           curr_Hole_id,
    output logic [2:0]           request_hole,
    output logic                 stage_load,
    output logic [3:0]           stage_num,
    output logic [3:0]           scoreL,
    output logic [3:0]           scoreH,
    output logic [2:0]           lives_left,
    output logic [7:0]           time_left,
    output logic                 winPulse,
    output logic                 losePulse,
    output logic                 game_over,
    output logic                 game_won
);

    localparam int c_PRESC_W = $clog2(CLK_HZ + 1);
    localparam logic [c_PRESC_W-1:0] c_LIMIT_NORMAL = c_PRESC_W'(CLK_HZ - 1);
    localparam logic [c_PRESC_W-1:0] c_LIMIT_TURBO  = c_PRESC_W'(CLK_HZ / 16 - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SETUP     = 3'd1;
    localparam logic [2:0] S_PLAY      = 3'd2;
    localparam logic [2:0] S_WIN_HOLD  = 3'd3;
    localparam logic [2:0] S_LOSE_HOLD = 3'd4;
    localparam logic [2:0] S_GAME_OVER = 3'd5;
    localparam logic [2:0] S_GAME_WON  = 3'd6;

    logic [2:0]           r_state;
    logic [2:0]           w_nextState;
    logic [c_PRESC_W-1:0] r_prescale;
    logic                 w_tick;
    logic [7:0]           r_holdCnt;
    logic [3:0]           r_stageNum;
    logic [3:0]           r_scoreL;
    logic [3:0]           r_scoreH;
    logic [2:0]           r_lives;
    logic [2:0]           r_reqHole;
    logic [7:0]           r_timeLeft;
    logic                 r_stageLoad;
    logic                 r_winPulse;
    logic                 r_losePulse;
    logic                 r_gameOver;
    logic                 r_gameWon;

    logic [NUM_BALLS-1:0] w_hits;
    logic [7:0]           w_nHits;
    logic [7:0]           w_points;
    logic [7:0]           w_scoreBin;
    logic [8:0]           w_scoreSum;
    logic [7:0]           w_scoreSat;
    logic [3:0]           w_newScoreH;
    logic [3:0]           w_newScoreL;
    logic [2:0]           w_nextHole;
    logic                 w_frame;
    logic                 w_whiteSunk;
    logic                 w_allCleared;
    logic                 w_timeout;
    logic                 w_winDone;
    logic                 w_loseDone;

    // Prescaler compares with >= so a turbo toggle mid-count cannot strand it
    // above the shorter wrap limit.
    assign w_tick = (r_prescale >= (turbo ? c_LIMIT_TURBO : c_LIMIT_NORMAL));

    // Coloured hits this frame and the points they are worth.
    always_comb begin
        w_hits  = ballhole_collide[NUM_BALLS:1] & balls_in_game[NUM_BALLS:1];
        w_nHits = 8'd0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            w_nHits = w_nHits + {7'd0, w_hits[i]};
        end
        w_points = (curr_Hole_id == r_reqHole) ? {w_nHits[6:0], 1'b0} : w_nHits;
    end

    // BCD add done in binary then split back into digits; saturates at 99.
    always_comb begin
        w_scoreBin  = 8'(r_scoreH) * 8'd10 + 8'(r_scoreL);
        w_scoreSum  = {1'b0, w_scoreBin} + {1'b0, w_points};
        w_scoreSat  = (w_scoreSum > 9'd99) ? 8'd99 : w_scoreSum[7:0];
        w_newScoreH = 4'(w_scoreSat / 8'd10);
        w_newScoreL = 4'(w_scoreSat % 8'd10);
        w_nextHole  = (r_reqHole == 3'(NUM_HOLES - 1)) ? 3'd0 : r_reqHole + 3'd1;
    end

    assign w_frame      = (r_state == S_PLAY) && startOfFrame;
    assign w_whiteSunk  = w_frame && ballhole_collide[0];
    // Win when no coloured ball remains once this frame's hits are removed.
    assign w_allCleared = w_frame && balls_in_game[0] &&
                          ((balls_in_game[NUM_BALLS:1] & ~w_hits) == '0);
    assign w_timeout    = (r_state == S_PLAY) && w_tick && (r_timeLeft == 8'd1);
    assign w_winDone    = w_tick && (r_holdCnt == 8'(WIN_HOLD_SEC - 1));
    assign w_loseDone   = w_tick && (r_holdCnt == 8'(LOSE_HOLD_SEC - 1));

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_game) w_nextState = S_SETUP;
            end
            S_SETUP: begin
                w_nextState = S_PLAY;
            end
            S_PLAY: begin
                // White ball loss outranks a simultaneous clear; frame events
                // outrank the countdown expiring in the same cycle.
                if (w_whiteSunk)       w_nextState = S_LOSE_HOLD;
                else if (w_allCleared) w_nextState = S_WIN_HOLD;
                else if (w_timeout)    w_nextState = S_LOSE_HOLD;
            end
            S_WIN_HOLD: begin
                if (w_winDone) begin
                    w_nextState = (r_stageNum == 4'(NUM_STAGES)) ? S_GAME_WON : S_SETUP;
                end
            end
            S_LOSE_HOLD: begin
                if (w_loseDone) begin
                    w_nextState = (r_lives == 3'd0) ? S_GAME_OVER : S_SETUP;
                end
            end
            S_GAME_OVER, S_GAME_WON: begin
                if (start_game) w_nextState = S_SETUP;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_prescale  <= '0;
            r_holdCnt   <= 8'd0;
            r_stageNum  <= 4'd1;
            r_scoreL    <= 4'd0;
            r_scoreH    <= 4'd0;
            r_lives     <= 3'(LIVES);
            r_reqHole   <= 3'd0;
            r_timeLeft  <= 8'(STAGE_SEC);
            r_stageLoad <= 1'b0;
            r_winPulse  <= 1'b0;
            r_losePulse <= 1'b0;
            r_gameOver  <= 1'b0;
            r_gameWon   <= 1'b0;
        end else begin
            r_state <= w_nextState;

            // Second timing restarts on every state entry.
            if (w_nextState != r_state || w_tick) r_prescale <= '0;
            else                                  r_prescale <= r_prescale + c_PRESC_W'(1);

            if (w_nextState != r_state) r_holdCnt <= 8'd0;
            else if (w_tick)            r_holdCnt <= r_holdCnt + 8'd1;

            // Flags track the state being entered so they are registered.
            r_stageLoad <= (w_nextState == S_SETUP);
            r_winPulse  <= (w_nextState == S_WIN_HOLD);
            r_losePulse <= (w_nextState == S_LOSE_HOLD);
            r_gameOver  <= (w_nextState == S_GAME_OVER);
            r_gameWon   <= (w_nextState == S_GAME_WON);

            case (r_state)
                S_SETUP: begin
                    r_timeLeft <= 8'(STAGE_SEC);
                end
                S_PLAY: begin
                    if (w_tick && r_timeLeft != 8'd0) r_timeLeft <= r_timeLeft - 8'd1;
                    if (w_frame && w_nHits != 8'd0) begin
                        r_scoreH  <= w_newScoreH;
                        r_scoreL  <= w_newScoreL;
                        r_reqHole <= w_nextHole;
                    end
                    if (w_nextState == S_LOSE_HOLD) begin
                        r_lives <= (r_lives == 3'd0) ? 3'd0 : r_lives - 3'd1;
                    end
                end
                S_WIN_HOLD: begin
                    if (w_winDone && r_stageNum != 4'(NUM_STAGES)) begin
                        r_stageNum <= r_stageNum + 4'd1;
                    end
                end
                S_GAME_OVER, S_GAME_WON: begin
                    if (start_game) begin
                        r_scoreH   <= 4'd0;
                        r_scoreL   <= 4'd0;
                        r_lives    <= 3'(LIVES);
                        r_stageNum <= 4'd1;
                        r_reqHole  <= 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign request_hole = r_reqHole;
    assign stage_load   = r_stageLoad;
    assign stage_num    = r_stageNum;
    assign scoreL       = r_scoreL;
    assign scoreH       = r_scoreH;
    assign lives_left   = r_lives;
    assign time_left    = r_timeLeft;
    assign winPulse     = r_winPulse;
    assign losePulse    = r_losePulse;
    assign game_over    = r_gameOver;
    assign game_won     = r_gameWon;

endmodule
`default_nettype wire

// File: tb/tb_game_stage_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_game_stage_controller                                       |
// | Purpose  : Self-checking bench for game_stage_controller. CLK_HZ=64 with  |
// |            turbo=1 gives a 4-cycle second.                                |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_game_stage_controller;

    logic       clk;
    logic       reset;
    logic       startOfFrame;
    logic       start_game;
    logic       turbo;
    logic [2:0] balls_in_game;
    logic [2:0] ballhole_collide;
    logic [2:0] curr_Hole_id;
    logic [2:0] request_hole;
    logic       stage_load;
    logic [3:0] stage_num;
    logic [3:0] scoreL;
    logic [3:0] scoreH;
    logic [2:0] lives_left;
    logic [7:0] time_left;
    logic       winPulse;
    logic       losePulse;
    logic       game_over;
    logic       game_won;

    int tests = 0;
    int fails = 0;

    game_stage_controller #(
        .NUM_BALLS    (2),
        .NUM_STAGES   (4),
        .NUM_HOLES    (6),
        .LIVES        (3),
        .CLK_HZ       (64),
        .STAGE_SEC    (60),
        .WIN_HOLD_SEC (2),
        .LOSE_HOLD_SEC(3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .startOfFrame    (startOfFrame),
        .start_game      (start_game),
        .turbo           (turbo),
        .balls_in_game   (balls_in_game),
        .ballhole_collide(ballhole_collide),
        .curr_Hole_id    (curr_Hole_id),
        .request_hole    (request_hole),
        .stage_load      (stage_load),
        .stage_num       (stage_num),
        .scoreL          (scoreL),
        .scoreH          (scoreH),
        .lives_left      (lives_left),
        .time_left       (time_left),
        .winPulse        (winPulse),
        .losePulse       (losePulse),
        .game_over       (game_over),
        .game_won        (game_won)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic       sof;
        logic [2:0] big;
        logic [2:0] col;
        logic [2:0] hole;
        logic [3:0] expH;
        logic [3:0] expL;
        logic [2:0] expRh;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        startOfFrame     = 1'b0;
        ballhole_collide = 3'b000;
        curr_Hole_id     = 3'd0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " stage_num"},    int'(stage_num), 1);
        check({tag, " scoreH"},       int'(scoreH), 0);
        check({tag, " scoreL"},       int'(scoreL), 0);
        check({tag, " lives_left"},   int'(lives_left), 3);
        check({tag, " time_left"},    int'(time_left), 60);
        check({tag, " request_hole"}, int'(request_hole), 0);
        check({tag, " flags"},
              int'({stage_load, winPulse, losePulse, game_over, game_won}), 0);
    endtask

    initial begin
        int cnt;
        int rh;

        // sof, balls_in_game, collide, hole -> scoreH, scoreL, request_hole
        vecs[0]  = '{1'b1, 3'b111, 3'b000, 3'd0, 4'd0, 4'd0, 3'd0};
        vecs[1]  = '{1'b1, 3'b111, 3'b010, 3'd0, 4'd0, 4'd2, 3'd1}; // bonus
        vecs[2]  = '{1'b1, 3'b111, 3'b100, 3'd3, 4'd0, 4'd3, 3'd2}; // plain
        vecs[3]  = '{1'b1, 3'b111, 3'b010, 3'd2, 4'd0, 4'd5, 3'd3}; // bonus
        vecs[4]  = '{1'b0, 3'b111, 3'b010, 3'd3, 4'd0, 4'd5, 3'd3}; // no strobe
        vecs[5]  = '{1'b1, 3'b011, 3'b100, 3'd3, 4'd0, 4'd5, 3'd3}; // ball off table
        vecs[6]  = '{1'b1, 3'b111, 3'b100, 3'd0, 4'd0, 4'd6, 3'd4};
        vecs[7]  = '{1'b1, 3'b111, 3'b010, 3'd4, 4'd0, 4'd8, 3'd5};
        vecs[8]  = '{1'b1, 3'b111, 3'b010, 3'd5, 4'd1, 4'd0, 3'd0}; // BCD carry, hole wrap
        vecs[9]  = '{1'b1, 3'b111, 3'b100, 3'd2, 4'd1, 4'd1, 3'd1};
        vecs[10] = '{1'b1, 3'b110, 3'b000, 3'd0, 4'd1, 4'd1, 3'd1}; // white absent, no win
        vecs[11] = '{1'b0, 3'b111, 3'b001, 3'd0, 4'd1, 4'd1, 3'd1}; // white hit w/o strobe

        reset         = 1'b1;
        start_game    = 1'b0;
        turbo         = 1'b1;
        balls_in_game = 3'b111;
        clear_inputs();

        step();
        step();
        check_reset_values("reset");
        reset = 1'b0;
        step();
        check("idle stage_load", int'(stage_load), 0);

        // Start: one-cycle stage_load, then play with a full clock.
        start_game = 1'b1;
        step();
        start_game = 1'b0;
        check("start stage_load", int'(stage_load), 1);
        check("start stage_num", int'(stage_num), 1);
        step();
        check("setup stage_load drops", int'(stage_load), 0);
        check("setup time_left", int'(time_left), 60);

        for (int i = 0; i < 12; i++) begin
            startOfFrame     = vecs[i].sof;
            balls_in_game    = vecs[i].big;
            ballhole_collide = vecs[i].col;
            curr_Hole_id     = vecs[i].hole;
            step();
            check($sformatf("vec%0d scoreH", i), int'(scoreH), int'(vecs[i].expH));
            check($sformatf("vec%0d scoreL", i), int'(scoreL), int'(vecs[i].expL));
            check($sformatf("vec%0d request_hole", i), int'(request_hole), int'(vecs[i].expRh));
            check($sformatf("vec%0d pulses", i), int'({winPulse, losePulse}), 0);
        end
        clear_inputs();
        balls_in_game = 3'b111;

        // White ball sinks with the last coloured ball: lose wins, point kept.
        startOfFrame     = 1'b1;
        balls_in_game    = 3'b101;
        ballhole_collide = 3'b101;
        curr_Hole_id     = 3'd4;
        step();
        check("white loss losePulse", int'(losePulse), 1);
        check("white loss winPulse", int'(winPulse), 0);
        check("white loss score", int'({scoreH, scoreL}), 8'h12);
        check("white loss lives", int'(lives_left), 2);
        // Inputs during the hold must be ignored.
        balls_in_game    = 3'b111;
        ballhole_collide = 3'b010;
        curr_Hole_id     = 3'd2;
        cnt = 0;
        while (losePulse && cnt < 100) begin
            step();
            cnt++;
        end
        clear_inputs();
        check("lose hold length", cnt, 12);
        check("lose hold score kept", int'({scoreH, scoreL}), 8'h12);
        check("lose hold restage", int'(stage_load), 1);
        check("lose hold stage_num", int'(stage_num), 1);

        // Two timeouts exhaust the remaining lives.
        for (int r = 0; r < 2; r++) begin
            step();
            check($sformatf("to%0d time start", r), int'(time_left), 60);
            step(); step(); step();
            check($sformatf("to%0d time before tick", r), int'(time_left), 60);
            step();
            check($sformatf("to%0d time first tick", r), int'(time_left), 59);
            cnt = 0;
            while (!losePulse && cnt < 400) begin
                step();
                cnt++;
            end
            check($sformatf("to%0d cycles to timeout", r), cnt, 236);
            check($sformatf("to%0d time_left", r), int'(time_left), 0);
            check($sformatf("to%0d lives", r), int'(lives_left), 1 - r);
            cnt = 0;
            while (losePulse && cnt < 100) begin
                step();
                cnt++;
            end
            check($sformatf("to%0d hold length", r), cnt, 12);
            check($sformatf("to%0d stage_load", r), int'(stage_load), (r == 0) ? 1 : 0);
            check($sformatf("to%0d game_over", r), int'(game_over), r);
        end
        step();
        check("game_over held", int'(game_over), 1);

        start_game = 1'b1;
        step();
        start_game = 1'b0;
        check("restart game_over", int'(game_over), 0);
        check("restart score", int'({scoreH, scoreL}), 0);
        check("restart lives", int'(lives_left), 3);
        check("restart stage_num", int'(stage_num), 1);
        check("restart stage_load", int'(stage_load), 1);

        // Clear every stage with both balls in a non-target hole (+2 each).
        for (int s = 1; s <= 4; s++) begin
            step();
            check($sformatf("st%0d stage_num", s), int'(stage_num), s);
            startOfFrame     = 1'b1;
            balls_in_game    = 3'b111;
            ballhole_collide = 3'b110;
            curr_Hole_id     = 3'd7;
            step();
            clear_inputs();
            check($sformatf("st%0d winPulse", s), int'(winPulse), 1);
            check($sformatf("st%0d score", s), int'(scoreL), 2 * s);
            cnt = 0;
            while (winPulse && cnt < 100) begin
                step();
                cnt++;
            end
            check($sformatf("st%0d win hold length", s), cnt, 8);
            if (s < 4) begin
                check($sformatf("st%0d next stage", s), int'(stage_num), s + 1);
                check($sformatf("st%0d stage_load", s), int'(stage_load), 1);
            end else begin
                check("final game_won", int'(game_won), 1);
                check("final stage_num", int'(stage_num), 4);
            end
        end

        start_game = 1'b1;
        step();
        start_game = 1'b0;
        check("won restart game_won", int'(game_won), 0);
        check("won restart score", int'({scoreH, scoreL}), 0);
        check("won restart stage_num", int'(stage_num), 1);
        check("won restart lives", int'(lives_left), 3);
        check("won restart request_hole", int'(request_hole), 0);

        // Build the score to 98 with 49 bonus single-ball hits.
        step();
        rh = 0;
        balls_in_game = 3'b111;
        for (int k = 0; k < 49; k++) begin
            startOfFrame     = 1'b1;
            ballhole_collide = 3'b010;
            curr_Hole_id     = 3'(rh);
            step();
            rh = (rh + 1) % 6;
        end
        clear_inputs();
        check("score 98", int'({scoreH, scoreL}), 8'h98);
        check("score 98 winPulse", int'(winPulse), 0);

        // Two-ball bonus hit (+4) saturates at 99 and clears the table.
        startOfFrame     = 1'b1;
        ballhole_collide = 3'b110;
        curr_Hole_id     = 3'(rh);
        step();
        clear_inputs();
        check("saturated score", int'({scoreH, scoreL}), 8'h99);
        check("saturate winPulse", int'(winPulse), 1);

        step(); step(); step();
        reset = 1'b1;
        step();
        check_reset_values("mid-hold reset");
        reset = 1'b0;
        step();
        check("post reset idle", int'(stage_load), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
